// File: rtl/fetch_stage.sv
// Fetch stage with F/D pipeline register: holds PCF, runs a one-outstanding
// request/valid handshake to instruction memory and feeds decode.
module fetch_stage #(
    parameter int           N        = 32,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         StallF,
    input  logic         StallD,
    input  logic         FlushD,
    input  logic         BranchTakenE,
    input  logic [N-1:0] BranchTargetE,
    input  logic         PCSrcW,
    input  logic [N-1:0] ResultW,
    output logic         IMemReqF,
    output logic [N-1:0] IMemAddrF,
    input  logic         IMemValidF,
    input  logic [N-1:0] IMemRdataF,
    output logic [N-1:0] PCPlus4F,
    output logic         FetchBusyF,
    output logic [N-1:0] InstrD,
    output logic [N-1:0] PCPlus8D,
    output logic         ValidD
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DROP
    } state_t;

    state_t       state, state_next;
    logic [N-1:0] pc, pc_next;
    logic [N-1:0] instr_buf;
    logic [N-1:0] deliver_data;
    logic         deliver;
    logic         buf_load;
    logic         redirect;
    logic [N-1:0] target;
    logic         advance;

    assign redirect  = PCSrcW | BranchTakenE;
    assign target    = PCSrcW ? ResultW : BranchTargetE;
    // A flush in the delivery cycle would destroy the instruction, so it is parked in HOLD instead.
    assign advance   = !StallF && !StallD && !FlushD;

    assign PCPlus4F  = pc + N'(4);
    assign IMemAddrF = pc;
    assign IMemReqF  = (state == REQ);

    always_comb begin
        state_next   = state;
        pc_next      = pc;
        deliver      = 1'b0;
        deliver_data = IMemRdataF;
        buf_load     = 1'b0;
        FetchBusyF   = 1'b1;
        case (state)
            IDLE: begin
                state_next = REQ;
                if (redirect) pc_next = target;
            end
            REQ: begin
                if (redirect) begin
                    pc_next    = target;
                    state_next = DROP;
                end else begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                FetchBusyF = !IMemValidF;
                if (redirect) begin
                    pc_next    = target;
                    state_next = IMemValidF ? REQ : DROP;
                end else if (IMemValidF) begin
                    if (advance) begin
                        deliver    = 1'b1;
                        pc_next    = PCPlus4F;
                        state_next = REQ;
                    end else begin
                        buf_load   = 1'b1;
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                FetchBusyF   = 1'b0;
                deliver_data = instr_buf;
                if (redirect) begin
                    pc_next    = target;
                    state_next = REQ;
                end else if (advance) begin
                    deliver    = 1'b1;
                    pc_next    = PCPlus4F;
                    state_next = REQ;
                end
            end
            DROP: begin
                // The stale response is the only one outstanding; once it lands we may re-request.
                if (redirect) pc_next = target;
                if (IMemValidF) state_next = REQ;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_load) instr_buf <= IMemRdataF;
    end

    // F/D register boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            InstrD   <= '0;
            PCPlus8D <= '0;
            ValidD   <= 1'b0;
        end else if (FlushD) begin
            InstrD   <= '0;
            PCPlus8D <= '0;
            ValidD   <= 1'b0;
        end else if (StallD) begin
            InstrD   <= InstrD;
            PCPlus8D <= PCPlus8D;
            ValidD   <= ValidD;
        end else if (deliver) begin
            InstrD   <= deliver_data;
            PCPlus8D <= pc + N'(8);
            ValidD   <= 1'b1;
        end else begin
            InstrD   <= '0;
            ValidD   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: cycle table for the 1-cycle memory case,
// then hand sequences for slow memory, redirects, reset and PC wrap.
module tb_fetch_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0;
    logic        BranchTakenE = 1'b0, PCSrcW = 1'b0;
    logic [31:0] BranchTargetE = '0, ResultW = '0;

    logic        req0, busy0, vd0;
    logic [31:0] addr0, pcp4_0, instr0, p8_0;
    logic        mv0 = 1'b0;
    logic [31:0] md0 = '0;

    logic        req1, busy1, vd1;
    logic [31:0] addr1, pcp4_1, instr1, p8_1;
    logic        mv1 = 1'b0;
    logic [31:0] md1 = '0;

    fetch_stage dut0 (
        .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .BranchTakenE(BranchTakenE), .BranchTargetE(BranchTargetE),
        .PCSrcW(PCSrcW), .ResultW(ResultW),
        .IMemReqF(req0), .IMemAddrF(addr0), .IMemValidF(mv0), .IMemRdataF(md0),
        .PCPlus4F(pcp4_0), .FetchBusyF(busy0),
        .InstrD(instr0), .PCPlus8D(p8_0), .ValidD(vd0)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .BranchTakenE(BranchTakenE), .BranchTargetE(BranchTargetE),
        .PCSrcW(PCSrcW), .ResultW(ResultW),
        .IMemReqF(req1), .IMemAddrF(addr1), .IMemValidF(mv1), .IMemRdataF(md1),
        .PCPlus4F(pcp4_1), .FetchBusyF(busy1),
        .InstrD(instr1), .PCPlus8D(p8_1), .ValidD(vd1)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hE000_0000 | a;
    endfunction

    // Memory for dut0 with programmable latency (cycles from request to valid)
    int          lat = 1;
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [31:0] maddr = '0;
    always @(posedge clk) begin
        mv0 <= 1'b0;
        if (pend) begin
            if (cnt <= 1) begin
                mv0  <= 1'b1;
                md0  <= mem_word(maddr);
                pend <= 1'b0;
            end else begin
                cnt <= cnt - 1;
            end
        end
        if (req0 === 1'b1) begin
            maddr <= addr0;
            if (lat <= 1) begin
                mv0  <= 1'b1;
                md0  <= mem_word(addr0);
                pend <= 1'b0;
            end else begin
                pend <= 1'b1;
                cnt  <= lat - 1;
            end
        end
    end

    // dut1 memory is fixed 1-cycle; log its first requests and first delivery
    logic [31:0] log1 [2];
    logic [1:0]  nlog1 = 2'd0;
    logic        got1 = 1'b0;
    logic [31:0] p8first1 = '0;
    always @(posedge clk) begin
        mv1 <= (req1 === 1'b1);
        md1 <= mem_word(addr1);
        if (!rst && req1 === 1'b1 && nlog1 < 2'd2) begin
            log1[nlog1[0]] <= addr1;
            nlog1 <= nlog1 + 2'd1;
        end
        if (!rst && vd1 === 1'b1 && !got1) begin
            got1     <= 1'b1;
            p8first1 <= p8_1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_vd(input string name);
        int k = 0;
        while (vd0 !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk({name, "_vd_timeout"}, 32'(vd0), 32'd1);
    endtask

    typedef struct {
        logic        stf, std, fld;
        logic        req;
        logic [31:0] addr;
        logic        busy, vd;
        logic [31:0] instr, p8;
    } vec_t;

    function automatic vec_t v(input logic [2:0] ctl, input logic req, input logic [31:0] addr,
                               input logic busy, input logic vd,
                               input logic [31:0] instr, input logic [31:0] p8);
        vec_t r;
        r.stf = ctl[2]; r.std = ctl[1]; r.fld = ctl[0];
        r.req = req; r.addr = addr; r.busy = busy; r.vd = vd; r.instr = instr; r.p8 = p8;
        return r;
    endfunction

    vec_t tbl [19];

    initial begin
        int n, bn, k, seen;

        //           {StallF,StallD,FlushD} req  addr   busy vd  InstrD        PCPlus8D
        tbl[0]  = v(3'b000, 1'b0, 32'h00, 1'b1, 1'b0, 32'h0,         32'h00);
        tbl[1]  = v(3'b000, 1'b1, 32'h00, 1'b1, 1'b0, 32'h0,         32'h00);
        tbl[2]  = v(3'b000, 1'b0, 32'h00, 1'b0, 1'b0, 32'h0,         32'h00);
        tbl[3]  = v(3'b000, 1'b1, 32'h04, 1'b1, 1'b1, 32'hE000_0000, 32'h08);
        tbl[4]  = v(3'b000, 1'b0, 32'h04, 1'b0, 1'b0, 32'h0,         32'h08);
        tbl[5]  = v(3'b000, 1'b1, 32'h08, 1'b1, 1'b1, 32'hE000_0004, 32'h0C);
        tbl[6]  = v(3'b000, 1'b0, 32'h08, 1'b0, 1'b0, 32'h0,         32'h0C);
        tbl[7]  = v(3'b000, 1'b1, 32'h0C, 1'b1, 1'b1, 32'hE000_0008, 32'h10);
        tbl[8]  = v(3'b110, 1'b0, 32'h0C, 1'b0, 1'b0, 32'h0,         32'h10);
        tbl[9]  = v(3'b110, 1'b0, 32'h0C, 1'b0, 1'b0, 32'h0,         32'h10);
        tbl[10] = v(3'b000, 1'b0, 32'h0C, 1'b0, 1'b0, 32'h0,         32'h10);
        tbl[11] = v(3'b000, 1'b1, 32'h10, 1'b1, 1'b1, 32'hE000_000C, 32'h14);
        tbl[12] = v(3'b110, 1'b0, 32'h10, 1'b0, 1'b0, 32'h0,         32'h14);
        tbl[13] = v(3'b001, 1'b0, 32'h10, 1'b0, 1'b0, 32'h0,         32'h14);
        tbl[14] = v(3'b000, 1'b0, 32'h10, 1'b0, 1'b0, 32'h0,         32'h00);
        tbl[15] = v(3'b001, 1'b1, 32'h14, 1'b1, 1'b1, 32'hE000_0010, 32'h18);
        tbl[16] = v(3'b001, 1'b0, 32'h14, 1'b0, 1'b0, 32'h0,         32'h00);
        tbl[17] = v(3'b000, 1'b0, 32'h14, 1'b0, 1'b0, 32'h0,         32'h00);
        tbl[18] = v(3'b000, 1'b1, 32'h18, 1'b1, 1'b1, 32'hE000_0014, 32'h1C);

        // Reset state, sampled while rst is still high
        tick();
        chk("rst_addr", addr0, 32'h0);
        chk("rst_req", 32'(req0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd1);
        chk("rst_vd", 32'(vd0), 32'd0);
        chk("rst_instr", instr0, 32'h0);
        chk("rst_p8", p8_0, 32'h0);
        chk("rst_addr_wrap", addr1, 32'hFFFF_FFFC);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            StallF = tbl[i].stf;
            StallD = tbl[i].std;
            FlushD = tbl[i].fld;
            #1;
            chk($sformatf("c%0d_req", i), 32'(req0), 32'(tbl[i].req));
            chk($sformatf("c%0d_addr", i), addr0, tbl[i].addr);
            chk($sformatf("c%0d_pcplus4", i), pcp4_0, tbl[i].addr + 32'd4);
            chk($sformatf("c%0d_busy", i), 32'(busy0), 32'(tbl[i].busy));
            chk($sformatf("c%0d_vd", i), 32'(vd0), 32'(tbl[i].vd));
            chk($sformatf("c%0d_instr", i), instr0, tbl[i].instr);
            chk($sformatf("c%0d_p8", i), p8_0, tbl[i].p8);
            @(negedge clk);
        end
        StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;

        // PC wrap instance: RESET_PC = 0xFFFFFFFC
        chk("wrap_req0", log1[0], 32'hFFFF_FFFC);
        chk("wrap_req1", log1[1], 32'h0);
        chk("wrap_got", 32'(got1), 32'd1);
        chk("wrap_p8", p8first1, 32'h4);

        // Memory latency 3
        lat = 3;
        #1;
        wait_vd("t2a");
        chk("t2a_instr", instr0, 32'hE000_0018);
        chk("t2a_p8", p8_0, 32'h20);
        n = 0; bn = 0;
        tick();
        while (vd0 !== 1'b1 && n < 20) begin
            n++;
            if (busy0 === 1'b1) bn++;
            tick();
        end
        chk("t2_bubbles", 32'(n), 32'd3);
        chk("t2_busy_cycles", 32'(bn), 32'd2);
        chk("t2b_instr", instr0, 32'hE000_001C);
        chk("t2b_p8", p8_0, 32'h24);

        // Branch during WAIT with no data yet: stale response dropped
        chk("t3_req", 32'(req0), 32'd1);
        chk("t3_addr", addr0, 32'h20);
        tick();
        chk("t3_wait_busy", 32'(busy0), 32'd1);
        chk("t3_wait_req", 32'(req0), 32'd0);
        BranchTakenE = 1'b1; BranchTargetE = 32'h40;
        tick();
        BranchTakenE = 1'b0;
        chk("t3_drop_addr", addr0, 32'h40);
        chk("t3_drop_busy", 32'(busy0), 32'd1);
        k = 0; seen = 0;
        while (req0 !== 1'b1 && k < 20) begin
            if (vd0 === 1'b1) seen++;
            tick();
            k++;
        end
        chk("t3_drop_cycles", 32'(k), 32'd2);
        chk("t3_newreq_addr", addr0, 32'h40);
        chk("t3_no_stale", 32'(seen), 32'd0);

        // Simultaneous redirects: writeback wins
        PCSrcW = 1'b1; ResultW = 32'h80;
        BranchTakenE = 1'b1; BranchTargetE = 32'h40;
        tick();
        PCSrcW = 1'b0; BranchTakenE = 1'b0;
        chk("t4_pc", addr0, 32'h80);
        k = 0; seen = 0;
        while (req0 !== 1'b1 && k < 20) begin
            if (vd0 === 1'b1) seen++;
            tick();
            k++;
        end
        chk("t4_drop_cycles", 32'(k), 32'd3);
        chk("t4_req_addr", addr0, 32'h80);
        chk("t4_no_stale", 32'(seen), 32'd0);
        wait_vd("t4");
        chk("t4_instr", instr0, 32'hE000_0080);
        chk("t4_p8", p8_0, 32'h88);

        // Reset mid-transaction; stale response lands while in REQ
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_idle_addr", addr0, 32'h0);
        chk("t5_idle_req", 32'(req0), 32'd0);
        chk("t5_idle_busy", 32'(busy0), 32'd1);
        chk("t5_idle_vd", 32'(vd0), 32'd0);
        chk("t5_idle_p8", p8_0, 32'h0);
        wait_vd("t5");
        chk("t5_instr", instr0, 32'hE000_0000);
        chk("t5_p8", p8_0, 32'h8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
